// File: rtl/mmss_timer_periph.sv
// mm:ss timer peripheral: memory-mapped CTRL/COUNT/STATUS registers, a
// one-second prescaler, a BCD up/down counter with wrap detection, and
// two synchronised, debounced control pins.
module mmss_timer_periph #(
    parameter int CLK_HZ          = 16000000,
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    input  logic        up_down_in,
    input  logic        start_stop_in,
    output logic [15:0] disp_value,
    output logic        colon,
    output logic        wrap_pulse
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Pin conditioning: bit 0 = up/down, bit 1 = start/stop
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_db;

    assign pin_raw = {start_stop_in, up_down_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pin
            logic          sync1_q;
            logic          sync2_q;
            logic          db_q;
            logic          db_d;
            logic [DW-1:0] stab_q;
            logic [DW-1:0] stab_d;

            // Two-flop synchroniser for the asynchronous raw pin
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= pin_raw[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Accept a change only after it has persisted; any reversion restarts the count
            always_comb begin
                db_d   = db_q;
                stab_d = '0;
                if (sync2_q != db_q) begin
                    if (stab_q == DB_LAST) begin
                        db_d = sync2_q;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end
            end

            // Debounced value and stability counter registers
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    db_q   <= 1'b0;
                    stab_q <= '0;
                end else begin
                    db_q   <= db_d;
                    stab_q <= stab_d;
                end
            end

            assign pin_db[gi] = db_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          ready_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    ctrl_q, ctrl_d;          // {src, sw_up, sw_run}
    logic [15:0]   count_q, count_d;        // BCD {M1,M0,S1,S0}
    logic          wrap_q, wrap_d;          // sticky STATUS.wrap
    logic          load_err_q, load_err_d;  // sticky STATUS.load_err
    logic          wrap_pulse_q, wrap_pulse_d;
    logic [PW-1:0] presc_q, presc_d;

    logic          running;
    logic          up;
    logic          tick;

    assign running = ctrl_q[2] ? ctrl_q[0] : pin_db[1];
    assign up      = ctrl_q[2] ? ctrl_q[1] : pin_db[0];
    assign tick    = running && (presc_q == PRESC_LAST);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic        sel;
    logic        wr_en;
    logic [1:0]  word;
    logic [15:0] count_merged;
    logic        count_merged_ok;
    logic        count_wr;
    logic        count_load;
    logic        load_err_set;
    logic        status_clr;

    assign sel   = iomem_valid && !ready_q && (iomem_addr[31:24] == 8'h04);
    assign word  = iomem_addr[3:2];
    assign wr_en = sel && (iomem_wstrb != 4'b0000);

    // COUNT only lives in the low two bytes; upper-byte-only writes are no-ops
    assign count_merged = {iomem_wstrb[1] ? iomem_wdata[15:8] : count_q[15:8],
                           iomem_wstrb[0] ? iomem_wdata[7:0]  : count_q[7:0]};
    assign count_merged_ok = (count_merged[15:12] <= 4'd9) && (count_merged[11:8] <= 4'd9) &&
                             (count_merged[7:4]   <= 4'd5) && (count_merged[3:0]  <= 4'd9);
    assign count_wr     = wr_en && (word == 2'd1) && (iomem_wstrb[1:0] != 2'b00);
    assign count_load   = count_wr && count_merged_ok;
    assign load_err_set = count_wr && !count_merged_ok;
    assign status_clr   = wr_en && (word == 2'd2) && iomem_wstrb[0];

    // ------------------------------------------------------------------
    // BCD step: one second forward or backward, flagging 99:59 <-> 00:00
    // ------------------------------------------------------------------
    logic [15:0] count_step;
    logic        count_step_wrap;

    // Ripple carry/borrow through the four BCD digits
    always_comb begin
        count_step      = count_q;
        count_step_wrap = 1'b0;
        if (up) begin
            if (count_q[3:0] != 4'd9) begin
                count_step[3:0] = count_q[3:0] + 4'd1;
            end else begin
                count_step[3:0] = 4'd0;
                if (count_q[7:4] != 4'd5) begin
                    count_step[7:4] = count_q[7:4] + 4'd1;
                end else begin
                    count_step[7:4] = 4'd0;
                    if (count_q[11:8] != 4'd9) begin
                        count_step[11:8] = count_q[11:8] + 4'd1;
                    end else begin
                        count_step[11:8] = 4'd0;
                        if (count_q[15:12] != 4'd9) begin
                            count_step[15:12] = count_q[15:12] + 4'd1;
                        end else begin
                            count_step[15:12] = 4'd0;
                            count_step_wrap   = 1'b1;
                        end
                    end
                end
            end
        end else begin
            if (count_q[3:0] != 4'd0) begin
                count_step[3:0] = count_q[3:0] - 4'd1;
            end else begin
                count_step[3:0] = 4'd9;
                if (count_q[7:4] != 4'd0) begin
                    count_step[7:4] = count_q[7:4] - 4'd1;
                end else begin
                    count_step[7:4] = 4'd5;
                    if (count_q[11:8] != 4'd0) begin
                        count_step[11:8] = count_q[11:8] - 4'd1;
                    end else begin
                        count_step[11:8] = 4'd9;
                        if (count_q[15:12] != 4'd0) begin
                            count_step[15:12] = count_q[15:12] - 4'd1;
                        end else begin
                            count_step[15:12] = 4'd9;
                            count_step_wrap   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [31:0] read_mux;

    // Register writes, prescaler, count update and read-data selection
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && (word == 2'd0) && iomem_wstrb[0]) begin
            ctrl_d = iomem_wdata[2:0];
        end

        // A tick either wraps the prescaler back to 0 or, when it collides with
        // a COUNT load, is dropped; either way the next second starts from 0.
        if (!running || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (count_load) begin
            count_d = count_merged;
        end else if (tick) begin
            count_d = count_step;
        end else begin
            count_d = count_q;
        end

        wrap_pulse_d = tick && !count_load && count_step_wrap;
        // Setting a sticky bit takes priority over clearing it in the same cycle
        wrap_d       = wrap_pulse_d || (wrap_q && !(status_clr && iomem_wdata[2]));
        load_err_d   = load_err_set || (load_err_q && !(status_clr && iomem_wdata[3]));

        case (word)
            2'd0:    read_mux = {29'd0, ctrl_q};
            2'd1:    read_mux = {16'd0, count_q};
            2'd2:    read_mux = {28'd0, load_err_q, wrap_q, up, running};
            default: read_mux = 32'd0;
        endcase
        rdata_d = sel ? read_mux : 32'd0;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q      <= 1'b0;
            rdata_q      <= 32'd0;
            ctrl_q       <= 3'd0;
            count_q      <= 16'h0000;
            wrap_q       <= 1'b0;
            load_err_q   <= 1'b0;
            wrap_pulse_q <= 1'b0;
            presc_q      <= '0;
        end else begin
            ready_q      <= sel;
            rdata_q      <= rdata_d;
            ctrl_q       <= ctrl_d;
            count_q      <= count_d;
            wrap_q       <= wrap_d;
            load_err_q   <= load_err_d;
            wrap_pulse_q <= wrap_pulse_d;
            presc_q      <= presc_d;
        end
    end

    // Address and data bits outside the decoded fields are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16]};

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign disp_value  = count_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign colon       = !running || (presc_q < PRESC_HALF);

endmodule

// File: doc/mmss_timer_periph.md
MMSS_TIMER_PERIPH -- requirements
Module: mmss_timer_periph

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 16000000, clock cycles per one-second tick.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16000, the number of consecutive stable cycles needed to accept a pin change.
REQ-003 The block SHALL have these ports: clk input 1 (system clock); resetn input 1 (synchronous, active-low reset).
REQ-004 The block SHALL have these bus ports: iomem_valid input 1; iomem_ready output 1; iomem_wstrb input 4; iomem_addr input 32; iomem_wdata input 32; iomem_rdata output 32.
REQ-005 The block SHALL have these pin and display ports: up_down_in input 1 (raw pin, high = up); start_stop_in input 1 (raw pin, high = run); disp_value output 16 (BCD {M1,M0,S1,S0}); colon output 1; wrap_pulse output 1 (one-cycle pulse on count wrap).

Function
REQ-006 Bus select SHALL be iomem_valid && !iomem_ready && iomem_addr[31:24]==8'h04; word select SHALL be iomem_addr[3:2].
REQ-007 On select, iomem_ready SHALL be 1 in the next cycle only, with iomem_rdata valid in that same cycle; otherwise iomem_ready SHALL be 0.
REQ-008 Writes SHALL take effect only when iomem_wstrb != 0; individual byte strobes SHALL be honoured.
REQ-009 Word 0, CTRL (R/W): bit0 sw_run, bit1 sw_up, bit2 src (0 = pins, 1 = CTRL bits); other bits SHALL read 0.
REQ-010 Word 1, COUNT: reads SHALL return {16'h0, disp_value}; writes SHALL load bits 15:0 only if every nibble is <=9 and S1 is <=5.
REQ-011 An invalid COUNT write SHALL leave the count unchanged and set STATUS.load_err.
REQ-012 Word 2, STATUS: bit0 running, bit1 up, bit2 wrap (sticky), bit3 load_err (sticky); writing 1 to bit2 or bit3 SHALL clear that bit.
REQ-013 Word 3 SHALL read 0, and writes to it SHALL be ignored.
REQ-014 Each raw pin SHALL pass through a 2-flop synchronizer.
REQ-015 The debounced pin value SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion SHALL reset the stability counter.
REQ-016 running SHALL be (src ? sw_run : db_start_stop); up SHALL be (src ? sw_up : db_up_down).
REQ-017 The prescaler SHALL count 0..CLK_HZ-1 while running and assert tick in the cycle it holds CLK_HZ-1, then return to 0.
REQ-018 While not running, the prescaler SHALL be held at 0 and no tick SHALL occur.
REQ-019 On a tick with up=1: S0 increments 9->0 with carry to S1; S1 5->0 with carry to M0; M0 9->0 with carry to M1; M1 9->0.
REQ-020 On a tick with up=1 at 99:59, the count SHALL go to 00:00 and wrap_pulse SHALL be 1 for that cycle.
REQ-021 On a tick with up=0, the count SHALL decrement with borrows (S0 0->9, S1 0->5, M0 0->9, M1 0->9).
REQ-022 On a tick with up=0 at 00:00, the count SHALL go to 99:59, wrap_pulse SHALL be 1, and STATUS.wrap SHALL be set.
REQ-023 The count SHALL update one cycle after tick; disp_value SHALL be registered.
REQ-024 If a valid COUNT write and a tick occur in the same cycle, the write SHALL win, the tick SHALL be discarded, and the prescaler SHALL restart at 0.
REQ-025 If a wrap sets STATUS.wrap in the same cycle as a write-1-to-clear of that bit, the set SHALL win.
REQ-026 colon SHALL be 1 while the prescaler is < CLK_HZ/2 and 0 otherwise when running, and SHALL be a constant 1 when stopped.
REQ-027 A change of the up signal mid-second SHALL not reset the prescaler.

Reset
REQ-028 When resetn=0 at a clk edge: disp_value=16'h0000, colon=1, wrap_pulse=0, iomem_ready=0, iomem_rdata=0, CTRL=0, STATUS sticky bits=0, prescaler=0.
REQ-029 When resetn=0 at a clk edge, the synchronizer and debounced values SHALL be 0 and the stability counters SHALL be 0.
REQ-030 Reset asserted mid-second or mid-transaction SHALL abandon the transaction, with no ready pulse after reset.

Verification (CLK_HZ=10, DEBOUNCE_CYCLES=4)
REQ-031 Stimulus: CTRL=3'b111, 25 clocks. Response: disp_value=16'h0002, and colon high for 5 cycles then low for 5 cycles in each second.
REQ-032 Stimulus: COUNT=16'h9959, up run for one tick. Response: disp_value=16'h0000, wrap_pulse one cycle, STATUS=4'b0111.
REQ-033 Stimulus: COUNT=16'h0100, down run for one tick. Response: disp_value=16'h0059.
REQ-034 Stimulus: COUNT write of 16'h0060. Response: count unchanged, STATUS.load_err=1; writing 32'h8 to STATUS clears it.
REQ-035 Stimulus: src=0, start_stop_in pulsed high for 3 cycles, then held high for 6 cycles. Response: the 3-cycle pulse is ignored; running rises 2+4 cycles after the stable high begins.
REQ-036 Stimulus: COUNT write landing on the tick cycle. Response: the written value is displayed, and the next tick arrives CLK_HZ cycles later.
